// File: rtl/hack_loader_pkg.sv
// hack_loader_pkg: FSM state type and lane helpers shared by the ioctl download loaders.
package hack_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
    FLUSH,
    DONE
  } load_state_t;

  function automatic int lane_lsb(input int lane, input int bytes_per_word, input bit big_endian);
    return big_endian ? 8 * (bytes_per_word - 1 - lane) : 8 * lane;
  endfunction

  function automatic int lane_bits(input int bytes_per_word);
    return bytes_per_word > 1 ? $clog2(bytes_per_word) : 1;
  endfunction

endpackage

// File: rtl/ioctl_word_loader_if.sv
// ioctl_word_loader_if: HPS ioctl byte stream, memory word write port and session status.
interface ioctl_word_loader_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_wait;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   word_count;
  logic [15:0]       checksum;
  logic              overflow;
  logic              proto_err;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_ready,
    input  ioctl_wait, mem_wr, mem_addr, mem_data, busy, done, word_count, checksum, overflow, proto_err
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_ready,
    output ioctl_wait, mem_wr, mem_addr, mem_data, busy, done, word_count, checksum, overflow, proto_err
  );
endinterface

// File: rtl/ioctl_word_asm.sv
// ioctl_word_asm: per-lane byte buffer and written-lane mask that assemble one memory word.
module ioctl_word_asm
  import hack_loader_pkg::*;
#(
  parameter int BYTES_PER_WORD = 2,
  parameter bit BIG_ENDIAN = 1'b1,
  localparam int DATA_W = 8 * BYTES_PER_WORD,
  localparam int LANE_W = lane_bits(BYTES_PER_WORD)
) (
  input  logic                      clk_sys,
  input  logic                      reset_n,
  input  logic                      clr,
  input  logic                      wr,
  input  logic [LANE_W-1:0]         lane,
  input  logic [7:0]                din,
  output logic [DATA_W-1:0]         word,
  output logic [BYTES_PER_WORD-1:0] mask
);

  logic [7:0] lanes [BYTES_PER_WORD];

  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      lanes <= '{default: '0};
      mask  <= '0;
    end else if (clr) begin
      lanes <= '{default: '0};
      mask  <= '0;
    end else begin
      for (int i = 0; i < BYTES_PER_WORD; i++)
        if (wr && lane == LANE_W'(i)) begin
          lanes[i] <= din;
          mask[i]  <= 1'b1;
        end
    end

  always_comb begin
    word = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++)
      word[lane_lsb(i, BYTES_PER_WORD, BIG_ENDIAN) +: 8] = lanes[i];
  end

endmodule

// File: rtl/ioctl_word_loader.sv
// ioctl_word_loader: packs ioctl download bytes into memory words and writes them with ready backpressure.
module ioctl_word_loader
  import hack_loader_pkg::*;
#(
  parameter int         BYTES_PER_WORD = 2,
  parameter int         ADDR_W         = 15,
  parameter int         DEPTH          = 2 ** ADDR_W,
  parameter bit         BIG_ENDIAN     = 1'b1,
  parameter logic [7:0] TARGET_INDEX   = 8'd0,
  localparam int        DATA_W         = 8 * BYTES_PER_WORD,
  localparam int        LANE_W         = lane_bits(BYTES_PER_WORD)
) (
  input logic clk_sys,
  input logic reset_n,
  ioctl_word_loader_if.slave bus
);

  load_state_t state, next_state;
  logic dl_q, start, last, in_range, accept, store, commit, mem_wr;
  logic [24:0] word_addr;
  logic [LANE_W-1:0] lane;
  logic [DATA_W-1:0] word;
  logic [BYTES_PER_WORD-1:0] mask;
  logic [ADDR_W-1:0] mem_addr;
  logic [ADDR_W:0] word_count;
  logic [15:0] checksum;
  logic overflow, proto_err;

  assign word_addr = bus.ioctl_addr / 25'(BYTES_PER_WORD);
  assign lane      = LANE_W'(bus.ioctl_addr % 25'(BYTES_PER_WORD));
  assign start     = state == IDLE && bus.ioctl_download && !dl_q && bus.ioctl_index == TARGET_INDEX;
  assign in_range  = word_addr < 25'(DEPTH);
  assign last      = lane == LANE_W'(BYTES_PER_WORD - 1);
  assign accept    = state == COLLECT && bus.ioctl_wr;
  assign store     = accept && in_range;
  assign commit    = mem_wr && bus.mem_ready;

  // out-of-range bytes never reach the buffer, so a flush only ever issues an in-range word
  ioctl_word_asm #(.BYTES_PER_WORD(BYTES_PER_WORD), .BIG_ENDIAN(BIG_ENDIAN)) u_asm (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .clr     (start || commit),
    .wr      (store),
    .lane    (lane),
    .din     (bus.ioctl_dout),
    .word    (word),
    .mask    (mask)
  );

  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= next_state;

  // a byte in the same cycle as the download fall is taken first; the fall is seen next cycle
  always_comb
    next_state = state == IDLE    ? (start ? COLLECT : IDLE)
               : state == COLLECT ? (bus.ioctl_wr ? (last && in_range ? WRITE : COLLECT)
                                   : !bus.ioctl_download ? (|mask ? FLUSH : DONE) : COLLECT)
               : state == WRITE   ? (bus.mem_ready ? COLLECT : WRITE)
               : state == FLUSH   ? (bus.mem_ready ? DONE : FLUSH)
               : IDLE;

  always_comb begin
    mem_wr   = state == WRITE || state == FLUSH;
    bus.busy = state == COLLECT || state == WRITE || state == FLUSH;
    bus.done = state == DONE;
  end

  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      dl_q       <= 1'b0;
      mem_addr   <= '0;
      word_count <= '0;
      checksum   <= '0;
      overflow   <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      dl_q <= bus.ioctl_download;
      if (start) begin
        word_count <= '0;
        checksum   <= '0;
        overflow   <= 1'b0;
        proto_err  <= 1'b0;
      end else begin
        if (store) mem_addr <= word_addr[ADDR_W-1:0];
        if (commit) word_count <= word_count + 1'b1;
        if (accept) checksum <= checksum + 16'(bus.ioctl_dout);
        if (accept && !in_range) overflow <= 1'b1;
        if (bus.ioctl_wr && mem_wr) proto_err <= 1'b1;
      end
    end

  assign bus.mem_wr     = mem_wr;
  assign bus.ioctl_wait = mem_wr;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_data   = word;
  assign bus.word_count = word_count;
  assign bus.checksum   = checksum;
  assign bus.overflow   = overflow;
  assign bus.proto_err  = proto_err;

endmodule

// File: tb/tb_ioctl_word_loader.sv
// tb_ioctl_word_loader: random download sessions against a behavioural loader model, plus directed literal checks.
module tb_ioctl_word_loader;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic dl = 1'b0, wr = 1'b0, rdy = 1'b1, rnd_rdy = 1'b0;
  logic [7:0] idx = 8'd0, dout = 8'd0;
  logic [24:0] addr = '0;
  int total = 0, bad = 0;

  ioctl_word_loader_if #(.ADDR_W(15), .DATA_W(16)) ifa ();
  ioctl_word_loader_if #(.ADDR_W(2), .DATA_W(32)) ifb ();
  ioctl_word_loader_if #(.ADDR_W(2), .DATA_W(16)) ifc ();

  assign {ifa.ioctl_download, ifa.ioctl_index, ifa.ioctl_wr, ifa.ioctl_addr, ifa.ioctl_dout, ifa.mem_ready} = {dl, idx, wr, addr, dout, rdy};
  assign {ifb.ioctl_download, ifb.ioctl_index, ifb.ioctl_wr, ifb.ioctl_addr, ifb.ioctl_dout, ifb.mem_ready} = {dl, idx, wr, addr, dout, rdy};
  assign {ifc.ioctl_download, ifc.ioctl_index, ifc.ioctl_wr, ifc.ioctl_addr, ifc.ioctl_dout, ifc.mem_ready} = {dl, idx, wr, addr, dout, rdy};

  ioctl_word_loader dut_a (.clk_sys(clk), .reset_n(rst_n), .bus(ifa));
  ioctl_word_loader #(.BYTES_PER_WORD(4), .ADDR_W(2), .BIG_ENDIAN(1'b0)) dut_b (.clk_sys(clk), .reset_n(rst_n), .bus(ifb));
  ioctl_word_loader #(.ADDR_W(2)) dut_c (.clk_sys(clk), .reset_n(rst_n), .bus(ifc));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model of the default instance (2-byte big-endian words, 32768 words, index 0)
  bit m_act, m_off, m_fin, m_done, m_pdl, m_ov, m_pe;
  bit [1:0] m_v;
  logic [7:0] m_b [2];
  int m_pa, m_wc, m_cs;

  always @(posedge clk or negedge rst_n) begin
    int wa, ln;
    if (!rst_n) begin
      {m_act, m_off, m_fin, m_done, m_pdl, m_ov, m_pe} = '0;
      m_v = '0;
      m_b = '{8'd0, 8'd0};
      m_pa = 0; m_wc = 0; m_cs = 0;
    end else begin
      if (m_done) m_done = 1'b0;
      else if (!m_act) begin
        if (dl && !m_pdl && idx == 8'd0) begin
          m_act = 1'b1; m_wc = 0; m_cs = 0; m_ov = 1'b0; m_pe = 1'b0;
          m_v = '0; m_b = '{8'd0, 8'd0};
        end
      end else if (m_off) begin
        if (wr) m_pe = 1'b1;
        if (rdy) begin
          m_wc++;
          m_v = '0; m_b = '{8'd0, 8'd0};
          m_off = 1'b0;
          if (m_fin) begin m_act = 1'b0; m_done = 1'b1; end
        end
      end else if (wr) begin
        m_cs = (m_cs + int'(dout)) % 65536;
        wa = int'(addr) / 2;
        ln = int'(addr) % 2;
        if (wa >= 32768) m_ov = 1'b1;
        else begin
          m_b[ln] = dout; m_v[ln] = 1'b1; m_pa = wa;
          if (ln == 1) begin m_off = 1'b1; m_fin = 1'b0; end
        end
      end else if (!dl) begin
        if (m_v != 2'b00) begin m_off = 1'b1; m_fin = 1'b1; end
        else begin m_act = 1'b0; m_done = 1'b1; end
      end
      m_pdl = dl;
    end
  end

  always @(negedge clk) begin
    chk("mem_wr", ifa.mem_wr, m_off);
    chk("ioctl_wait", ifa.ioctl_wait, m_off);
    chk("busy", ifa.busy, m_act);
    chk("done", ifa.done, m_done);
    chk("word_count", ifa.word_count, m_wc);
    chk("checksum", ifa.checksum, m_cs);
    chk("overflow", ifa.overflow, m_ov);
    chk("proto_err", ifa.proto_err, m_pe);
    if (m_off) begin
      chk("mem_addr", ifa.mem_addr, m_pa);
      chk("mem_data", ifa.mem_data, {m_b[0], m_b[1]});
    end
  end

  logic [14:0] la_a [$];
  logic [15:0] la_d [$];
  int b_n = 0, c_n = 0, a_done = 0;
  logic [1:0] b_a = '0;
  logic [31:0] b_d = '0;

  always @(negedge clk) begin
    if (ifa.mem_wr && ifa.mem_ready) begin la_a.push_back(ifa.mem_addr); la_d.push_back(ifa.mem_data); end
    if (ifb.mem_wr && ifb.mem_ready) begin b_n++; b_a = ifb.mem_addr; b_d = ifb.mem_data; end
    if (ifc.mem_wr && ifc.mem_ready) c_n++;
    if (ifa.done) a_done++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) rdy = $urandom_range(0, 3) != 0;
  endtask

  task automatic send(input int a, input logic [7:0] d, input bit patient);
    int n = 0;
    while (patient && (ifa.ioctl_wait || ifb.ioctl_wait || ifc.ioctl_wait) && n < 200) begin
      tick();
      n++;
    end
    chk("wait_bound", n < 200, 1);
    wr = 1'b1; addr = 25'(a); dout = d;
    tick();
    wr = 1'b0;
  endtask

  task automatic begin_session(input logic [7:0] i);
    idx = i; dl = 1'b1;
    tick();
  endtask

  task automatic end_session();
    int n = 0;
    dl = 1'b0;
    while ((ifa.busy || ifb.busy || ifc.busy) && n < 200) begin
      tick();
      n++;
    end
    chk("busy_bound", n < 200, 1);
    tick();
    tick();
  endtask

  task automatic clear_logs();
    la_a.delete();
    la_d.delete();
  endtask

  initial begin
    int n, base, b0, c0, d0;
    repeat (3) tick();
    chk("rst_mem_wr", ifa.mem_wr, 0);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_word_count", ifa.word_count, 0);
    chk("rst_checksum", ifa.checksum, 0);
    chk("rst_b_mem_data", ifb.mem_data, 0);
    rst_n = 1'b1;
    tick();

    clear_logs(); c0 = c_n;
    begin_session(8'd0); send(0, 8'h12, 1); send(1, 8'h34, 1); end_session();
    chk("be_writes", la_a.size(), 1);
    chk("be_addr", la_a[0], 0);
    chk("be_data", la_d[0], 16'h1234);
    chk("be_word_count", ifa.word_count, 1);
    chk("be_checksum", ifa.checksum, 16'h0046);
    chk("model_checksum", m_cs, 16'h0046);
    chk("b_partial_flush", b_d, 32'h0000_3412);
    chk("c_writes", c_n - c0, 1);

    clear_logs(); b0 = b_n;
    begin_session(8'd0);
    send(8, 8'hAA, 1); send(9, 8'hBB, 1); send(10, 8'hCC, 1); send(11, 8'hDD, 1);
    end_session();
    chk("le_writes", b_n - b0, 1);
    chk("le_addr", b_a, 2);
    chk("le_data", b_d, 32'hDDCC_BBAA);
    chk("a_hi_word", la_d[1], 16'hCCDD);

    clear_logs(); d0 = a_done;
    begin_session(8'd0); send(0, 8'h01, 1); send(1, 8'h02, 1); send(2, 8'h03, 1); end_session();
    chk("flush_writes", la_a.size(), 2);
    chk("flush_d0", la_d[0], 16'h0102);
    chk("flush_a1", la_a[1], 1);
    chk("flush_d1", la_d[1], 16'h0300);
    chk("flush_done", a_done - d0, 1);
    chk("flush_word_count", ifa.word_count, 2);
    chk("b_flush_data", b_d, 32'h0003_0201);

    clear_logs(); rdy = 1'b0;
    begin_session(8'd0); send(2, 8'hAB, 1); send(3, 8'hCD, 1);
    for (int k = 0; k < 5; k++) begin
      chk("stall_mem_wr", ifa.mem_wr, 1);
      chk("stall_wait", ifa.ioctl_wait, 1);
      chk("stall_data", ifa.mem_data, 16'hABCD);
      tick();
    end
    send(4, 8'hEE, 0);
    chk("stall_proto_err", ifa.proto_err, 1);
    chk("stall_checksum", ifa.checksum, 16'h0178);
    rdy = 1'b1;
    end_session();
    chk("stall_addr", la_a[0], 1);
    chk("stall_word_count", ifa.word_count, 1);

    c0 = c_n;
    begin_session(8'd0); send(8, 8'h11, 1); send(9, 8'h22, 1); end_session();
    chk("ovf_no_write", c_n - c0, 0);
    chk("ovf_set", ifc.overflow, 1);
    begin_session(8'd0);
    chk("ovf_cleared", ifc.overflow, 0);
    end_session();

    clear_logs(); d0 = a_done;
    begin_session(8'd7); send(0, 8'h55, 1); send(1, 8'h66, 1); end_session();
    chk("foreign_writes", la_a.size(), 0);
    chk("foreign_done", a_done - d0, 0);

    rdy = 1'b0;
    begin_session(8'd0); send(0, 8'h12, 1); send(1, 8'h34, 1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mem_wr", ifa.mem_wr, 0);
    chk("arst_wait", ifa.ioctl_wait, 0);
    chk("arst_busy", ifa.busy, 0);
    chk("arst_mem_data", ifa.mem_data, 0);
    chk("arst_word_count", ifa.word_count, 0);
    chk("arst_checksum", ifa.checksum, 0);
    chk("arst_mem_addr", ifa.mem_addr, 0);
    dl = 1'b0; rdy = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    clear_logs();
    begin_session(8'd0); send(0, 8'h12, 1); send(1, 8'h34, 1); end_session();
    chk("post_rst_data", la_d[0], 16'h1234);
    chk("post_rst_checksum", ifa.checksum, 16'h0046);

    rnd_rdy = 1'b1;
    for (int s = 0; s < 40; s++) begin
      n = $urandom_range(0, 7);
      base = ($urandom_range(0, 5) == 0) ? 65533 + $urandom_range(0, 2) : $urandom_range(0, 40);
      begin_session(($urandom_range(0, 4) == 0) ? 8'd3 : 8'd0);
      for (int k = 0; k < n; k++) send(base + k, 8'($urandom), $urandom_range(0, 7) != 0);
      repeat ($urandom_range(0, 2)) tick();
      end_session();
    end
    rnd_rdy = 1'b0; rdy = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
